// File: rtl/fifo_burst_reader.sv
// Burst read master for the synchronous FIFO: fetches BURST_LEN bytes per burst into a
// 2-entry skid buffer feeding a valid/ready stream. `define FIFO_BURST_READER_STATS_EN adds pop/stall counters.
module fifo_burst_reader #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk_single_domain,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              ren,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              err_unexpected
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [31:0]       stat_bytes,
  output logic [31:0]       stat_stall
`endif
);

  localparam int            CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   occ_q, occ_d;
  logic                         inflight_q;
  logic [CW-1:0]                issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]                deliv_cnt_q, deliv_cnt_d;
  logic [1:0][DATA_W-1:0]       dat_q, dat_d;
  logic [1:0]                   lst_q, lst_d;
  logic                         err_q, err_d;
  logic                         pop, push, push_last;
  logic [2:0]                   pend;

  assign m_valid        = (occ_q != 2'd0);
  assign m_data         = dat_q[0];
  assign m_last         = lst_q[0];
  assign pop            = m_valid & m_ready;
  assign busy           = (state_q != IDLE);
  assign err_unexpected = err_q;

  // Room check counts the byte leaving this cycle so a full buffer can still stream 1 byte/cycle.
  assign pend = {1'b0, occ_q} + {2'b00, inflight_q};
  assign ren  = (state_q == FETCH) && !empty && (issue_cnt_q < BL) &&
                (pend < (3'd2 + {2'b00, pop}));

  // issue_cnt has already advanced past the byte now returning, so it equals index+1.
  assign push      = rvalid & inflight_q;
  assign push_last = (issue_cnt_q == BL);
  assign err_d     = err_q | (rvalid & ~inflight_q);

  always_comb begin
    dat_d = dat_q;
    lst_d = lst_q;
    occ_d = occ_q;
    if (pop) begin
      dat_d[0] = dat_q[1];
      lst_d[0] = lst_q[1];
      occ_d    = occ_q - 2'd1;
    end
    if (push) begin
      dat_d[occ_d[0]] = rdata;
      lst_d[occ_d[0]] = push_last;
      occ_d           = occ_d + 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    deliv_cnt_d = deliv_cnt_q;
    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        deliv_cnt_d = '0;
        if (enable && !empty) state_d = FETCH;
      end
      FETCH: begin
        if (ren) issue_cnt_d = issue_cnt_q + 1'b1;
        if (pop) deliv_cnt_d = deliv_cnt_q + 1'b1;
        if (issue_cnt_d == BL) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop) deliv_cnt_d = deliv_cnt_q + 1'b1;
        if (deliv_cnt_d == BL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_single_domain) begin
    if (rst) begin
      state_q     <= IDLE;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      issue_cnt_q <= '0;
      deliv_cnt_q <= '0;
      dat_q       <= '0;
      lst_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      inflight_q  <= ren;
      issue_cnt_q <= issue_cnt_d;
      deliv_cnt_q <= deliv_cnt_d;
      dat_q       <= dat_d;
      lst_q       <= lst_d;
      err_q       <= err_d;
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  always_ff @(posedge clk_single_domain) begin
    if (rst) begin
      stat_bytes <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && !(&stat_bytes)) stat_bytes <= stat_bytes + 32'd1;
      if (m_valid && !m_ready && !(&stat_stall)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO responder model, directed scenarios and a randomized phase,
// all stream bytes checked against a queue model of the expected byte order and burst boundaries.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst, enable, empty, m_ready, force_rv;
  logic          rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          ren, m_valid, m_last, busy, err;
  logic [DW-1:0] m_data;

  logic [7:0]    mem [256];
  logic [7:0]    wptr = 8'd0;
  logic [7:0]    rptr = 8'd0;
  logic          fr_acc, fr_frc;

  logic [7:0]    avail_q [$];
  logic          fly_v = 1'b0;
  logic [7:0]    fly_d = 8'd0;
  int            pos = 0;

  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;
  assign empty = (wptr == rptr);

  fifo_burst_reader #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk_single_domain(clk), .rst(rst), .enable(enable), .empty(empty),
    .rdata(rdata), .rvalid(rvalid), .ren(ren), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .err_unexpected(err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    mem[wptr] = b;
    wptr = wptr + 8'd1;
  endtask

  // FIFO read port: accepts ren when non-empty, returns the byte one cycle later.
  always @(posedge clk) begin
    fr_acc = ren && !empty;
    fr_frc = force_rv;
    #1;
    if (fr_acc) begin
      rdata  = mem[rptr];
      rptr   = rptr + 8'd1;
      rvalid = 1'b1;
    end else if (fr_frc) begin
      rdata  = 8'hEE;
      rvalid = 1'b1;
    end else begin
      rvalid = 1'b0;
    end
  end

  // Model: a byte read in cycle N is on the stream from cycle N+2 until popped;
  // bytes leave in FIFO order and every BL-th delivered byte closes a burst.
  always @(negedge clk) begin
    if (rst) begin
      avail_q.delete();
      fly_v = 1'b0;
      pos   = 0;
    end else begin
      chk("m_valid", int'(m_valid), int'(avail_q.size() != 0));
      if (m_valid && avail_q.size() != 0) begin
        chk("m_data", int'(m_data), int'(avail_q[0]));
        chk("m_last", int'(m_last), int'(pos == BL - 1));
        if (m_ready) begin
          void'(avail_q.pop_front());
          pos = (pos + 1) % BL;
        end
      end
      if (fly_v) avail_q.push_back(fly_d);
      fly_v = 1'b0;
      if (ren) begin
        chk("ren_while_empty", int'(empty), 0);
        chk("ren_while_idle", int'(busy), 1);
        fly_v = 1'b1;
        fly_d = mem[rptr];
      end
      chk("buffered_bytes", avail_q.size() + int'(fly_v), (avail_q.size() + int'(fly_v) > 2) ? 2 : avail_q.size() + int'(fly_v));
    end
  end

  task automatic run_idle(input int maxc, output int pops, output int lasts, output int lastd);
    pops = 0; lasts = 0; lastd = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        pops++;
        if (m_last) begin lasts++; lastd = int'(m_data); end
      end
      if (!busy && !m_valid) break;
    end
    chk("burst_finished", int'(busy), 0);
  endtask

  initial begin
    logic [7:0]  r8, v8, l8, b8, lm;
    logic [7:0]  d8 [8];
    logic [31:0] renv;
    int          p, l, ld, r, np;
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; force_rv = 1'b0;
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    step(); step();
    @(negedge clk);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_ren", int'(ren), 0);

    // Full-rate burst with cycle-exact expectations.
    step(); rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r8[i] = ren; v8[i] = m_valid; l8[i] = m_last; b8[i] = busy; d8[i] = m_data;
    end
    chk("t1_ren_cycles", int'(r8), 32'h1E);
    chk("t1_valid_cycles", int'(v8), 32'h78);
    chk("t1_last_cycles", int'(l8), 32'h40);
    chk("t1_busy_cycles", int'(b8), 32'h7E);
    chk("t1_byte0", int'(d8[3]), 32'h11);
    chk("t1_byte1", int'(d8[4]), 32'h22);
    chk("t1_byte2", int'(d8[5]), 32'h33);
    chk("t1_byte3", int'(d8[6]), 32'h44);

    // Back-pressure right from the first read.
    step(); enable = 1'b0;
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ren) break;
    end
    chk("t2_first_ren", int'(ren), 1);
    r = 1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); r += int'(ren); end
    chk("t2_ren_during_stall", r, 2);
    chk("t2_valid_held", int'(m_valid), 1);
    chk("t2_head_held", int'(m_data), 32'h11);
    step(); m_ready = 1'b1; enable = 1'b0;
    run_idle(40, p, l, ld);
    chk("t2_pops", p, 4);
    chk("t2_lasts", l, 1);
    chk("t2_last_byte", ld, 32'h44);

    // FIFO runs dry mid-burst; burst waits for the refill.
    step(); wr(8'hA0); wr(8'hA1); enable = 1'b1; m_ready = 1'b1;
    r = 0; np = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r += int'(ren);
      np += int'(m_valid && m_ready);
    end
    chk("t3_ren_before_refill", r, 2);
    chk("t3_pops_before_refill", np, 2);
    chk("t3_busy_waiting", int'(busy), 1);
    step(); wr(8'hA2); wr(8'hA3); enable = 1'b0;
    run_idle(40, p, l, ld);
    chk("t3_pops_after_refill", p, 2);
    chk("t3_lasts", l, 1);
    chk("t3_last_byte", ld, 32'hA3);

    // Two back-to-back bursts.
    step(); for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
    enable = 1'b1; m_ready = 1'b1;
    renv = '0; lm = '0; np = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      renv[i] = ren;
      if (m_valid && m_ready) begin
        if (m_last && np < 8) lm[np] = 1'b1;
        np++;
      end
    end
    chk("t4_pops", np, 8);
    chk("t4_last_positions", int'(lm), 32'h88);
    chk("t4_ren_cycles", int'(renv), 32'hF1E);

    // Reset while draining with both skid entries full.
    step(); enable = 1'b0;
    wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4);
    enable = 1'b1; m_ready = 1'b1;
    np = 0;
    for (int i = 0; i < 20 && np < 2; i++) begin
      @(negedge clk);
      np += int'(m_valid && m_ready);
    end
    chk("t5_two_pops", np, 2);
    step(); m_ready = 1'b0; enable = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t5_full_valid", int'(m_valid), 1);
    chk("t5_full_busy", int'(busy), 1);
    chk("t5_model_two_held", avail_q.size(), 2);
    step(); rst = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t5_post_rst_valid", int'(m_valid), 0);
    chk("t5_post_rst_busy", int'(busy), 0);
    chk("t5_post_rst_last", int'(m_last), 0);
    np = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); np += int'(m_valid); end
    chk("t5_no_stale_bytes", np, 0);

    // rvalid with nothing outstanding.
    step(); force_rv = 1'b1;
    step(); force_rv = 1'b0;
    step();
    @(negedge clk);
    chk("t6_err_set", int'(err), 1);
    chk("t6_stream_quiet", int'(m_valid), 0);

    // Randomized traffic, enable and back-pressure.
    for (int i = 0; i < 400; i++) begin
      step();
      if ($urandom_range(0, 1) == 1 && (wptr - rptr) < 8'd200) wr(8'($urandom_range(0, 255)));
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
    end
    step();
    while (wptr[1:0] != 2'b00) wr(8'h5A);
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (empty && !busy && !m_valid) break;
    end
    chk("rand_drained", int'({empty, busy, m_valid}), 32'h4);
    chk("err_sticky", int'(err), 1);

    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_rst", int'(err), 0);
    chk("final_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
